// File: rtl/pixel_stream_feeder_if.sv
// Start/pixel/done link between the frame feeder (master) and the 2-D conv engine (slave).
interface pixel_stream_feeder_if;
  logic       start_signal;
  logic [7:0] pixel_in;
  logic       pixel_valid;
  logic       done_signal;

  modport master (
    output start_signal,
    output pixel_in,
    output pixel_valid,
    input  done_signal
  );

  modport slave (
    input  start_signal,
    input  pixel_in,
    input  pixel_valid,
    output done_signal
  );
endinterface

// File: rtl/pixel_stream_feeder.sv
// Frame source for the 2-D conv engine: host-loaded frame RAM streamed in raster order after a start pulse.
// Optional feature: define FEEDER_PATTERN_EN to add the pattern_mode input (x + 2*y test pattern).
module pixel_stream_feeder #(
  parameter int IMG_WIDTH    = 32,
  parameter int IMG_HEIGHT   = 32,
  parameter int DONE_TIMEOUT = 64,
  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT,
  localparam int AW   = $clog2(NPIX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  output logic          wr_reject,
  input  logic          go,
  input  logic          hold,
`ifdef FEEDER_PATTERN_EN
  input  logic          pattern_mode,
`endif
  output logic          busy,
  output logic          frame_done,
  output logic          timeout_err,
  pixel_stream_feeder_if.master eng
);

  localparam int TW = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
  localparam logic [TW-1:0] LAST_WAIT = TW'(DONE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_WAIT
  } state_t;

  state_t state, state_nx;

  logic [7:0]    frame_ram [NPIX];
  logic [AW-1:0] rd_addr;
  logic [TW-1:0] wait_cnt;
  logic          issue_p0;
  logic          done_hit_p0;
  logic          tmo_hit_p0;
  logic          go_accept_p0;
  logic [7:0]    pix_p0;

  assign go_accept_p0 = (state == S_IDLE) && go;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rd_addr  <= '0;
      wait_cnt <= '0;
    end else begin
      state <= state_nx;
      if (go_accept_p0) begin
        rd_addr <= '0;
      end else if (issue_p0) begin
        rd_addr <= (rd_addr == LAST_ADDR) ? '0 : rd_addr + 1'b1;
      end
      wait_cnt <= (state == S_WAIT) ? wait_cnt + 1'b1 : '0;
    end
  end

  // Done is checked before the timeout so a done on the final counted cycle still wins.
  always_comb begin
    state_nx    = state;
    issue_p0    = 1'b0;
    done_hit_p0 = 1'b0;
    tmo_hit_p0  = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) state_nx = S_START;
      end
      S_START: begin
        state_nx = S_STREAM;
      end
      S_STREAM: begin
        if (!hold) begin
          issue_p0 = 1'b1;
          if (rd_addr == LAST_ADDR) state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (eng.done_signal) begin
          done_hit_p0 = 1'b1;
          state_nx    = S_IDLE;
        end else if (wait_cnt == LAST_WAIT) begin
          tmo_hit_p0 = 1'b1;
          state_nx   = S_IDLE;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

`ifdef FEEDER_PATTERN_EN
  localparam int XW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  logic          pat_q;
  logic [XW-1:0] x_cnt;
  logic [YW-1:0] y_cnt;
  logic [7:0]    pat_pix;

  // x/y walk in lock-step with rd_addr so both modes share identical issue timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q <= 1'b0;
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (go_accept_p0) begin
      pat_q <= pattern_mode;
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (issue_p0) begin
      if (x_cnt == XW'(IMG_WIDTH - 1)) begin
        x_cnt <= '0;
        y_cnt <= (y_cnt == YW'(IMG_HEIGHT - 1)) ? '0 : y_cnt + 1'b1;
      end else begin
        x_cnt <= x_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    pat_pix = 8'(32'(x_cnt) + 2 * 32'(y_cnt));
    pix_p0  = pat_q ? pat_pix : frame_ram[rd_addr];
  end
`else
  always_comb begin
    pix_p0 = frame_ram[rd_addr];
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst && wr_en && (state == S_IDLE)) begin
      frame_ram[wr_addr] <= wr_data;
    end
  end

  // p1: registered outputs, one cycle behind the issue decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      timeout_err      <= 1'b0;
      wr_reject        <= 1'b0;
      eng.start_signal <= 1'b0;
      eng.pixel_valid  <= 1'b0;
      eng.pixel_in     <= '0;
    end else begin
      busy             <= (state_nx != S_IDLE);
      frame_done       <= done_hit_p0;
      timeout_err      <= tmo_hit_p0;
      wr_reject        <= wr_en && (state != S_IDLE);
      eng.start_signal <= go_accept_p0;
      eng.pixel_valid  <= issue_p0;
      if (issue_p0) eng.pixel_in <= pix_p0;
    end
  end

endmodule

// File: tb/tb_pixel_stream_feeder.sv
// Self-checking bench for pixel_stream_feeder: randomized frames against a raster-order reference model.
module tb_pixel_stream_feeder;
  localparam int W     = 32;
  localparam int H     = 32;
  localparam int TMO   = 64;
  localparam int NPIX  = W * H;
  localparam int AW    = $clog2(NPIX);
  localparam int LIMIT = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          go = 1'b0;
  logic          hold = 1'b0;
  logic          wr_reject, busy, frame_done, timeout_err;
`ifdef FEEDER_PATTERN_EN
  logic          pattern_mode = 1'b0;
`endif

  pixel_stream_feeder_if eng_if ();

  pixel_stream_feeder #(
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .DONE_TIMEOUT(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_reject   (wr_reject),
    .go          (go),
    .hold        (hold),
`ifdef FEEDER_PATTERN_EN
    .pattern_mode(pattern_mode),
`endif
    .busy        (busy),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .eng         (eng_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit         use_pat = 1'b0;
  logic [7:0] ram_model [NPIX];

  logic [7:0] rx_q [$];
  bit   vld_log  [LIMIT];
  bit   hold_log [LIMIT];
  bit   busy_log [LIMIT];
  int   t_start, t_first, t_last, t_done, t_tmo, t_rej, t_inj;
  int   n_start, n_done, n_tmo, n_rej;
  bit   timed_out, rst_obs_valid, rst_obs_busy;
  int   first_bad;

  function automatic logic [7:0] exp_pix(int i);
    if (use_pat) return 8'((i % W) + 2 * (i / W));
    return ram_model[i];
  endfunction

  function automatic int data_errs();
    int e = 0;
    first_bad = -1;
    for (int i = 0; i < rx_q.size() && i < NPIX; i++) begin
      if (rx_q[i] !== exp_pix(i)) begin
        e++;
        if (first_bad < 0) first_bad = i;
      end
    end
    return e;
  endfunction

  function automatic int hold_rule_errs();
    int e = 0;
    if (t_start < 0 || t_last < 0) return 1;
    for (int c = t_start + 2; c <= t_last; c++) begin
      if (vld_log[c] != !hold_log[c-1]) e++;
    end
    return e;
  endfunction

  function automatic int holds_in_stream();
    int n = 0;
    if (t_start < 0 || t_last < 0) return -1;
    for (int c = t_start + 1; c < t_last; c++) if (hold_log[c]) n++;
    return n;
  endfunction

  task automatic write_ram(input int addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_addr = AW'(addr);
    wr_data = data;
    ram_model[addr] = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Drives one frame from go, plays the engine side, logs every cycle; tests do the checking.
  task automatic run_frame(input int hold_mode, input int done_dly, input int early_done_at,
                           input int inj_at, input int rst_at, input bit wr_with_go,
                           input int gw_addr, input logic [7:0] gw_data);
    int ph      = $urandom_range(0, 2);
    int end_cyc = -1;
    bit injected = 1'b0, rst_fired = 1'b0, early_fired = 1'b0;
    t_start = -1; t_first = -1; t_last = -1; t_done = -1; t_tmo = -1; t_rej = -1; t_inj = -1;
    n_start = 0; n_done = 0; n_tmo = 0; n_rej = 0;
    rst_obs_valid = 1'b1; rst_obs_busy = 1'b1;
    rx_q.delete();
    for (int i = 0; i < LIMIT; i++) begin
      vld_log[i] = 1'b0; hold_log[i] = 1'b0; busy_log[i] = 1'b0;
    end
    timed_out = 1'b1;
    go   = 1'b1;
    hold = 1'b0;
    if (wr_with_go) begin
      wr_en = 1'b1; wr_addr = AW'(gw_addr); wr_data = gw_data;
    end
    for (int cyc = 1; cyc < LIMIT; cyc++) begin
      @(posedge clk); #1;
      go = 1'b0; wr_en = 1'b0; rst = 1'b0; hold = 1'b0; eng_if.done_signal = 1'b0;
      vld_log[cyc]  = eng_if.pixel_valid;
      busy_log[cyc] = busy;
      if (rst_fired) begin
        rst_obs_valid = eng_if.pixel_valid;
        rst_obs_busy  = busy;
        timed_out     = 1'b0;
        break;
      end
      if (eng_if.start_signal) begin
        n_start++;
        if (t_start < 0) t_start = cyc;
      end
      if (eng_if.pixel_valid) begin
        rx_q.push_back(eng_if.pixel_in);
        if (t_first < 0) t_first = cyc;
        t_last = cyc;
      end
      if (frame_done) begin
        n_done++;
        if (t_done < 0) t_done = cyc;
        if (end_cyc < 0) end_cyc = cyc + 2;
      end
      if (timeout_err) begin
        n_tmo++;
        if (t_tmo < 0) t_tmo = cyc;
        if (end_cyc < 0) end_cyc = cyc + 2;
      end
      if (wr_reject) begin
        n_rej++;
        t_rej = cyc;
      end
      if (end_cyc >= 0 && cyc >= end_cyc) begin
        timed_out = 1'b0;
        break;
      end
      case (hold_mode)
        3:       hold = ((cyc + ph) % 3 == 0);
        -1:      hold = ($urandom_range(0, 3) == 0);
        default: hold = 1'b0;
      endcase
      hold_log[cyc] = hold;
      if (done_dly >= 0 && rx_q.size() == NPIX && cyc == t_last + done_dly) eng_if.done_signal = 1'b1;
      if (early_done_at >= 0 && !early_fired && rx_q.size() == early_done_at) begin
        eng_if.done_signal = 1'b1;
        early_fired = 1'b1;
      end
      if (inj_at >= 0 && !injected && rx_q.size() == inj_at) begin
        wr_en   = 1'b1;
        go      = 1'b1;
        wr_addr = AW'($urandom_range(0, NPIX - 1));
        wr_data = ~ram_model[wr_addr];
        t_inj   = cyc;
        injected = 1'b1;
      end
      if (rst_at >= 0 && !rst_fired && rx_q.size() == rst_at) begin
        rst = 1'b1;
        rst_fired = 1'b1;
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0; wr_en = 1'b0; hold = 1'b0; eng_if.done_signal = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, frame_done, timeout_err, wr_reject} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_status: got %b expected 0000", {busy, frame_done, timeout_err, wr_reject});
    end
    n_checks++;
    if ({eng_if.start_signal, eng_if.pixel_valid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_stream: got %b expected 00", {eng_if.start_signal, eng_if.pixel_valid});
    end
    n_checks++;
    if (eng_if.pixel_in !== 8'h00) begin
      n_fail++; $display("FAIL reset_pixel_in: got %0h expected 0", eng_if.pixel_in);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_load_ram();
    int rej = 0;
    for (int i = 0; i < NPIX; i++) begin
      write_ram(i, 8'(i));
      if (wr_reject) rej++;
    end
    @(posedge clk); #1;
    if (wr_reject) rej++;
    n_checks++;
    if (rej !== 0) begin
      n_fail++; $display("FAIL load_reject: got %0d expected 0", rej);
    end
  endtask

  task automatic test_basic_frame();
    int e, b;
    run_frame(0, 1, -1, -1, -1, 1'b0, 0, 8'h00);
    n_checks++;
    if (timed_out) begin n_fail++; $display("FAIL basic_timeout: got 1 expected 0"); end
    n_checks++;
    if (t_start !== 1) begin n_fail++; $display("FAIL basic_t_start: got %0d expected 1", t_start); end
    n_checks++;
    if (t_first !== t_start + 2) begin n_fail++; $display("FAIL basic_t_first: got %0d expected %0d", t_first, t_start + 2); end
    n_checks++;
    if (t_last !== t_start + 1025) begin n_fail++; $display("FAIL basic_t_last: got %0d expected %0d", t_last, t_start + 1025); end
    n_checks++;
    if (t_done !== t_start + 1027) begin n_fail++; $display("FAIL basic_t_done: got %0d expected %0d", t_done, t_start + 1027); end
    n_checks++;
    if (rx_q.size() !== NPIX) begin n_fail++; $display("FAIL basic_count: got %0d expected %0d", rx_q.size(), NPIX); end
    e = data_errs();
    n_checks++;
    if (e !== 0) begin n_fail++; $display("FAIL basic_data: got %0d bad pixels (first %0d) expected 0", e, first_bad); end
    n_checks++;
    if ({n_start, n_done, n_tmo} !== {32'd1, 32'd1, 32'd0}) begin
      n_fail++; $display("FAIL basic_pulses: got start=%0d done=%0d tmo=%0d expected 1 1 0", n_start, n_done, n_tmo);
    end
    b = (t_start >= 0) ? int'(busy_log[t_start]) : 0;
    n_checks++;
    if (b !== 1) begin n_fail++; $display("FAIL basic_busy_start: got %0d expected 1", b); end
    b = (t_done >= 0) ? int'(busy_log[t_done + 1]) : 1;
    n_checks++;
    if (b !== 0) begin n_fail++; $display("FAIL basic_busy_after: got %0d expected 0", b); end
  endtask

  task automatic test_hold();
    int e, span, nh;
    run_frame(3, 1, -1, -1, -1, 1'b0, 0, 8'h00);
    n_checks++;
    if (timed_out || rx_q.size() !== NPIX) begin
      n_fail++; $display("FAIL hold_count: got %0d expected %0d (timed_out=%0d)", rx_q.size(), NPIX, timed_out);
    end
    e = data_errs();
    n_checks++;
    if (e !== 0) begin n_fail++; $display("FAIL hold_data: got %0d bad pixels (first %0d) expected 0", e, first_bad); end
    e = hold_rule_errs();
    n_checks++;
    if (e !== 0) begin n_fail++; $display("FAIL hold_gap_rule: got %0d violations expected 0", e); end
    span = t_last - t_start - 1;
    nh   = holds_in_stream();
    n_checks++;
    if (span !== NPIX + nh) begin n_fail++; $display("FAIL hold_span: got %0d expected %0d", span, NPIX + nh); end
    n_checks++;
    if (t_done !== t_last + 2) begin n_fail++; $display("FAIL hold_done: got %0d expected %0d", t_done, t_last + 2); end
  endtask

  task automatic test_timeout();
    int b;
    run_frame(-1, -1, -1, -1, -1, 1'b0, 0, 8'h00);
    n_checks++;
    if (timed_out || t_tmo !== t_last + TMO) begin
      n_fail++; $display("FAIL tmo_time: got %0d expected %0d", t_tmo, t_last + TMO);
    end
    n_checks++;
    if ({n_done, n_tmo} !== {32'd0, 32'd1}) begin
      n_fail++; $display("FAIL tmo_pulses: got done=%0d tmo=%0d expected 0 1", n_done, n_tmo);
    end
    b = (t_tmo >= 0) ? int'(busy_log[t_tmo + 1]) : 1;
    n_checks++;
    if (b !== 0) begin n_fail++; $display("FAIL tmo_busy_after: got %0d expected 0", b); end
    n_checks++;
    if (rx_q.size() !== NPIX) begin n_fail++; $display("FAIL tmo_count: got %0d expected %0d", rx_q.size(), NPIX); end
  endtask

  task automatic test_done_boundary();
    run_frame(0, TMO - 1, 100, -1, -1, 1'b0, 0, 8'h00);
    n_checks++;
    if (timed_out || t_done !== t_last + TMO) begin
      n_fail++; $display("FAIL edge_done_time: got %0d expected %0d", t_done, t_last + TMO);
    end
    n_checks++;
    if ({n_done, n_tmo} !== {32'd1, 32'd0}) begin
      n_fail++; $display("FAIL edge_pulses: got done=%0d tmo=%0d expected 1 0", n_done, n_tmo);
    end
    n_checks++;
    if (rx_q.size() !== NPIX) begin n_fail++; $display("FAIL edge_early_done_count: got %0d expected %0d", rx_q.size(), NPIX); end
  endtask

  task automatic test_busy_write_go();
    int e;
    run_frame(-1, 1, -1, 300, -1, 1'b0, 0, 8'h00);
    n_checks++;
    if (n_rej !== 1 || t_rej !== t_inj + 1) begin
      n_fail++; $display("FAIL busy_wr_reject: got n=%0d at %0d expected 1 at %0d", n_rej, t_rej, t_inj + 1);
    end
    n_checks++;
    if (n_start !== 1 || n_done !== 1) begin
      n_fail++; $display("FAIL busy_go_ignored: got start=%0d done=%0d expected 1 1", n_start, n_done);
    end
    e = data_errs();
    n_checks++;
    if (e !== 0 || rx_q.size() !== NPIX) begin
      n_fail++; $display("FAIL busy_frame_data: got %0d bad, %0d pixels expected 0, %0d", e, rx_q.size(), NPIX);
    end
    run_frame(0, 1, -1, -1, -1, 1'b0, 0, 8'h00);
    e = data_errs();
    n_checks++;
    if (e !== 0 || rx_q.size() !== NPIX) begin
      n_fail++; $display("FAIL busy_ram_unchanged: got %0d bad (first %0d) expected 0", e, first_bad);
    end
  endtask

  task automatic test_reset_abort();
    int e;
    run_frame(0, 1, -1, -1, 500, 1'b0, 0, 8'h00);
    n_checks++;
    if (timed_out || rst_obs_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_valid: got %0d expected 0", rst_obs_valid);
    end
    n_checks++;
    if (rst_obs_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0d expected 0", rst_obs_busy); end
    run_frame(-1, 1, -1, -1, -1, 1'b0, 0, 8'h00);
    e = data_errs();
    n_checks++;
    if (timed_out || e !== 0 || rx_q.size() !== NPIX) begin
      n_fail++; $display("FAIL abort_refill: got %0d bad, %0d pixels expected 0, %0d", e, rx_q.size(), NPIX);
    end
  endtask

  task automatic test_write_with_go();
    int a = $urandom_range(0, NPIX - 1);
    logic [7:0] d = 8'($urandom);
    int e;
    ram_model[a] = d;
    run_frame(0, 1, -1, -1, -1, 1'b1, a, d);
    n_checks++;
    if (t_start !== 1) begin n_fail++; $display("FAIL wrgo_start: got %0d expected 1", t_start); end
    e = data_errs();
    n_checks++;
    if (e !== 0 || rx_q.size() !== NPIX) begin
      n_fail++; $display("FAIL wrgo_data: got %0d bad (first %0d) expected 0", e, first_bad);
    end
  endtask

  task automatic test_back_to_back();
    int e;
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < 20; k++) write_ram($urandom_range(0, NPIX - 1), 8'($urandom));
      run_frame(-1, $urandom_range(1, TMO - 1), -1, -1, -1, 1'b0, 0, 8'h00);
      e = data_errs() + hold_rule_errs();
      n_checks++;
      if (timed_out || e !== 0 || rx_q.size() !== NPIX) begin
        n_fail++; $display("FAIL b2b_frame%0d: got %0d errors, %0d pixels expected 0, %0d", f, e, rx_q.size(), NPIX);
      end
      n_checks++;
      if ({n_done, n_tmo} !== {32'd1, 32'd0}) begin
        n_fail++; $display("FAIL b2b_pulses%0d: got done=%0d tmo=%0d expected 1 0", f, n_done, n_tmo);
      end
    end
  endtask

`ifdef FEEDER_PATTERN_EN
  task automatic test_pattern();
    int e;
    use_pat = 1'b1;
    pattern_mode = 1'b1;
    run_frame(-1, 1, -1, -1, -1, 1'b0, 0, 8'h00);
    n_checks++;
    if (rx_q[2 * W + 3] !== 8'd7) begin n_fail++; $display("FAIL pattern_x3y2: got %0d expected 7", rx_q[2 * W + 3]); end
    n_checks++;
    if (rx_q[NPIX - 1] !== 8'd93) begin n_fail++; $display("FAIL pattern_last: got %0d expected 93", rx_q[NPIX - 1]); end
    e = data_errs();
    n_checks++;
    if (e !== 0 || rx_q.size() !== NPIX) begin
      n_fail++; $display("FAIL pattern_data: got %0d bad (first %0d) expected 0", e, first_bad);
    end
    use_pat = 1'b0;
    pattern_mode = 1'b0;
  endtask
`endif

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    eng_if.done_signal = 1'b0;
    test_reset();
    test_load_ram();
    test_basic_frame();
    test_hold();
    test_timeout();
    test_done_boundary();
    test_busy_write_go();
    test_reset_abort();
    test_write_with_go();
    test_back_to_back();
`ifdef FEEDER_PATTERN_EN
    test_pattern();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
